// File: rtl/prefetch_buffer_pkg.sv
// Shared types and defaults for the instruction prefetch buffer.
package prefetch_buffer_pkg;

    localparam int unsigned PFB_DEPTH = 4;
    localparam int unsigned PFB_TAG_W = 4;
    localparam int unsigned ADDR_W    = 64;
    localparam int unsigned DATA_W    = 64;
    localparam int unsigned OFFSET_W  = 3;
    localparam int unsigned LINE_W    = ADDR_W - OFFSET_W;

    typedef enum logic [1:0] {
        BUS_NONE = 2'b00,
        BUS_LOAD = 2'b01
    } bus_cmd_e;

    typedef enum logic [1:0] {
        INVALID = 2'b00,
        PENDING = 2'b01,
        VALID   = 2'b10
    } entry_state_e;

    // Line address of a byte address (drops the 8-byte offset).
    function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:OFFSET_W];
    endfunction

endpackage

// File: rtl/prefetch_buffer_entry.sv
// One prefetch buffer entry: state, line address, tag and data, plus its compares.
module prefetch_buffer_entry
    import prefetch_buffer_pkg::*;
#(
    parameter int unsigned TAG_W = PFB_TAG_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              alloc,
    input  logic [LINE_W-1:0] alloc_line,
    input  logic [TAG_W-1:0]  alloc_tag,
    input  logic [TAG_W-1:0]  ret_tag,
    input  logic [DATA_W-1:0] ret_data,
    input  logic [LINE_W-1:0] pf_line,
    input  logic [LINE_W-1:0] lookup_line,
    output logic              pending,
    output logic              dup_hit,
    output logic              lookup_hit,
    output logic              ret_lookup,
    output logic [DATA_W-1:0] line_data
);

    entry_state_e      state_q;
    entry_state_e      state_d;
    logic [LINE_W-1:0] line_q;
    logic [TAG_W-1:0]  tag_q;
    logic [DATA_W-1:0] data_q;
    logic              ret_match;

    // A return matches only a pending entry carrying the same nonzero tag.
    assign ret_match = (state_q == PENDING) && (ret_tag != '0) && (ret_tag == tag_q);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= INVALID;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: flush dominates, then allocation, then data return.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = INVALID;
        end else if (alloc) begin
            state_d = PENDING;
        end else if (ret_match) begin
            state_d = VALID;
        end
    end

    // Payload capture on allocation and on a live return.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            line_q <= '0;
            tag_q  <= '0;
            data_q <= '0;
        end else begin
            if (alloc) begin
                line_q <= alloc_line;
                tag_q  <= alloc_tag;
            end
            if (ret_match && !flush) begin
                data_q <= ret_data;
            end
        end
    end

    // Compare outputs seen by the buffer.
    always_comb begin
        pending    = (state_q == PENDING);
        dup_hit    = (state_q != INVALID) && (line_q == pf_line);
        lookup_hit = (state_q == VALID) && (line_q == lookup_line);
        ret_lookup = ret_match && (line_q == lookup_line);
        line_data  = data_q;
    end

endmodule

// File: rtl/prefetch_buffer.sv
// Instruction prefetch buffer: issues line loads, tracks tags, serves fetch lookups.
// Optional build macro: PFB_BYPASS_EN forwards a same-cycle return to the lookup port.
module prefetch_buffer
    import prefetch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = PFB_DEPTH,
    parameter int unsigned TAG_W = PFB_TAG_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pf_request,
    input  logic [63:0]       pf_addr,
    output logic              pf_grant,
    input  logic              mem_busy,
    output logic [1:0]        buf2mem_command,
    output logic [63:0]       buf2mem_addr,
    input  logic [TAG_W-1:0]  mem2buf_response,
    input  logic [TAG_W-1:0]  mem2buf_tag,
    input  logic [63:0]       mem2buf_data,
    input  logic              flush,
    input  logic [63:0]       if_addr,
    output logic              if_hit,
    output logic [63:0]       if_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  alloc_ptr;
    logic [LINE_W-1:0] pf_line;
    logic [LINE_W-1:0] if_line;
    logic [DEPTH-1:0]  pending_vec;
    logic [DEPTH-1:0]  dup_vec;
    logic [DEPTH-1:0]  hit_vec;
    logic [DEPTH-1:0]  ret_lookup_vec;
    logic [DEPTH-1:0]  alloc_vec;
    logic [DATA_W-1:0] data_arr [DEPTH];
    logic              dup_c;
    logic              issue_c;
    logic              accept_c;
    logic              unused_low_bits;

    assign pf_line         = line_of(pf_addr);
    assign if_line         = line_of(if_addr);
    assign unused_low_bits = ^{pf_addr[OFFSET_W-1:0], if_addr[OFFSET_W-1:0]};

    // Entry array; only the victim named by alloc_ptr is written on acceptance.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        assign alloc_vec[i] = accept_c && (alloc_ptr == PTR_W'(i));

        prefetch_buffer_entry #(.TAG_W(TAG_W)) u_entry (
            .clock       (clock),
            .reset       (reset),
            .flush       (flush),
            .alloc       (alloc_vec[i]),
            .alloc_line  (pf_line),
            .alloc_tag   (mem2buf_response),
            .ret_tag     (mem2buf_tag),
            .ret_data    (mem2buf_data),
            .pf_line     (pf_line),
            .lookup_line (if_line),
            .pending     (pending_vec[i]),
            .dup_hit     (dup_vec[i]),
            .lookup_hit  (hit_vec[i]),
            .ret_lookup  (ret_lookup_vec[i]),
            .line_data   (data_arr[i])
        );
    end

    // FIFO replacement pointer; wraps naturally since DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alloc_ptr <= '0;
        end else if (flush) begin
            alloc_ptr <= '0;
        end else if (accept_c) begin
            alloc_ptr <= alloc_ptr + PTR_W'(1);
        end
    end

    // Issue, acceptance and prefetcher grant.
    always_comb begin
        dup_c           = |dup_vec;
        issue_c         = pf_request && !dup_c && !mem_busy && !flush && !pending_vec[alloc_ptr];
        accept_c        = issue_c && (mem2buf_response != '0);
        buf2mem_command = issue_c ? BUS_LOAD : BUS_NONE;
        buf2mem_addr    = {pf_line, OFFSET_W'(0)};
        pf_grant        = accept_c || (pf_request && dup_c && !flush);
    end

    // Lookup mux; at most one valid entry can match a line.
    always_comb begin
        if_hit  = 1'b0;
        if_data = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (hit_vec[i]) begin
                if_hit  = 1'b1;
                if_data = if_data | data_arr[i];
            end
        end
`ifdef PFB_BYPASS_EN
        if ((|ret_lookup_vec) && !flush) begin
            if_hit  = 1'b1;
            if_data = mem2buf_data;
        end
`endif
    end

`ifndef PFB_BYPASS_EN
    logic unused_ret_lookup;
    assign unused_ret_lookup = |ret_lookup_vec;
`endif

endmodule

// File: doc/prefetch_buffer.md
# prefetch_buffer

Instruction prefetch buffer between the instruction prefetcher and instruction memory. It turns the prefetcher's line address and request into memory load commands, and tracks each accepted command by its memory tag. It captures the returned 64-bit lines and serves fetch-stage lookups from the buffered lines. It also returns the grant that advances the prefetcher's address.

## Interface
Parameters:
- DEPTH, 4: number of buffer entries; power of two, ≥2.
- TAG_W, 4: memory tag width; tag value 0 means "no tag".

Ports:
- clock, input, 1: the only clock; all state updates on rising edge.
- reset, input, 1: asynchronous, active-low reset.
- pf_request, input, 1: prefetcher has a valid address.
- pf_addr, input, 64: prefetch line address; bits [2:0] are ignored.
- pf_grant, output, 1: prefetcher may advance to its next address this cycle.
- mem_busy, input, 1: load/store unit owns the memory port this cycle.
- buf2mem_command, output, 2: BUS_NONE or BUS_LOAD.
- buf2mem_addr, output, 64: equals {pf_addr[63:3], 3'b0}.
- mem2buf_response, input, TAG_W: nonzero means the command was accepted with that tag.
- mem2buf_tag, input, TAG_W: nonzero means a data return for that tag.
- mem2buf_data, input, 64: returned line, valid when mem2buf_tag ≠ 0.
- flush, input, 1: redirect or mispredict; invalidate the whole buffer.
- if_addr, input, 64: fetch lookup address; bits [2:0] are ignored.
- if_hit, output, 1: if_addr line is present and VALID.
- if_data, output, 64: line for if_addr when if_hit is 1, otherwise 0.

## Operation
- Each entry holds a state (INVALID, PENDING or VALID), a 61-bit line address, a TAG_W-bit tag and 64 bits of data.
- alloc_ptr (log2 DEPTH bits) names the victim entry and gives FIFO replacement.
- dup: pf_addr[63:3] matches any entry that is PENDING or VALID.
- Issue condition: pf_request & !dup & !mem_busy & !flush & victim not PENDING. When met, buf2mem_command = BUS_LOAD; otherwise BUS_NONE.
- Acceptance: issue condition met and mem2buf_response ≠ 0. On acceptance:
  - the victim entry becomes PENDING with pf_addr[63:3] and the response tag;
  - alloc_ptr increments, wrapping modulo DEPTH;
  - pf_grant = 1.
- Issue with mem2buf_response = 0: nothing is recorded, pf_grant = 0, and the request is retried next cycle.
- pf_request & dup & !flush: pf_grant = 1 with no command issued, so the prefetcher skips lines already buffered.
- Return: mem2buf_tag ≠ 0 matching a PENDING entry's tag sets that entry VALID and stores mem2buf_data. A tag with no PENDING match is dropped silently.
- Victim PENDING: the buffer is full of outstanding lines. No issue and pf_grant = 0 until that entry returns.
- Lookup: if_hit = OR over VALID entries whose address equals if_addr[63:3]; if_data comes from the matching entry. Duplicate suppression guarantees at most one match.
- flush:
  - every entry becomes INVALID and alloc_ptr resets to 0 at the next edge;
  - no command is issued in the flush cycle and pf_grant = 0;
  - returns for tags issued before the flush find no PENDING entry and are dropped;
  - a return in the same cycle as flush is dropped.

## Timing
- Reset (asynchronous assert): all entries INVALID, alloc_ptr = 0. Outputs: buf2mem_command = BUS_NONE, pf_grant = 0, if_hit = 0, if_data = 0.
- buf2mem_command, buf2mem_addr, pf_grant, if_hit and if_data are combinational from the current state and inputs.
- An entry accepted in cycle N is PENDING from cycle N+1, so dup suppression applies from N+1.
- A return in cycle N makes the entry VALID from N+1. Without bypass, if_hit for that line first asserts in N+1.
- Acceptance and a return for the victim's old tag in the same cycle cannot occur, because a PENDING victim blocks issue.
- A return and a new acceptance to a different entry in the same cycle are both applied.

## Configuration
- PFB_BYPASS_EN defined: a return in cycle N whose PENDING entry address equals if_addr[63:3] drives if_hit = 1 and if_data = mem2buf_data in cycle N. This bypass is suppressed if flush is asserted.
- PFB_BYPASS_EN undefined: no forwarding; the earliest hit is N+1.

## Structure
- Shared package contents:
  - bus command encoding (BUS_NONE, BUS_LOAD);
  - entry state enum (INVALID, PENDING, VALID);
  - default DEPTH and TAG_W.
- Sub-module prefetch_buffer_entry: holds one entry's state, address, tag and data. It provides the lookup compare, dup compare and tag-match compare. prefetch_buffer instantiates DEPTH copies and owns alloc_ptr, issue logic and output muxing.

## Test plan
- Reset, then pf_request = 1, pf_addr = 0x100, response = 3 → BUS_LOAD to 0x100, pf_grant = 1. Entry 0 is PENDING with tag 3.
- Tag 3 returns with data 0xDEAD in cycle N; if_addr = 0x104 → if_hit = 0 in N, if_hit = 1 and if_data = 0xDEAD in N+1. With PFB_BYPASS_EN, the hit is in N.
- pf_addr = 0x100 again while PENDING or VALID → BUS_NONE, pf_grant = 1.
- Four accepted requests (tags 1–4) with no returns, then a fifth → BUS_NONE, pf_grant = 0. After tag 1 returns, the fifth issues and replaces entry 0.
- mem_busy = 1, or response = 0 → pf_grant = 0, no allocation; the request retries next cycle.
- flush while two entries are PENDING, then their tags return → returns dropped, if_hit stays 0, alloc_ptr = 0.
